// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, queue entry layout
// and the default bubble word.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched words with their PC+4.
// Flush wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                wr_instr,
    input  logic [31:0]                wr_pc4,
    output logic [31:0]                head_instr,
    output logic [31:0]                head_pc4,
    output logic [$clog2(DEPTH):0]     count
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the top gates the head with the occupancy.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= '{instr: wr_instr, pc4: wr_pc4};
    end

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc4   = mem[rd_ptr].pc4;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC, runs the req/ack handshake to instruction
// memory and buffers returned words ahead of the IF/ID register.
//
// state   | meaning
// IDLE    | no request outstanding
// BUSY    | request outstanding, response will be queued
// DISCARD | request outstanding, response dropped after a redirect
module instruction_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       IF_ID_write,
    input  logic                       PCSrc,
    input  logic [31:0]                PC_next_MEM,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic [31:0]                instruction_IF,
    output logic [31:0]                PC_sumado_IF,
    output logic                       valid_IF,
    output logic [$clog2(DEPTH):0]     count
);
    import fetch_pkg::*;

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   next_pc;
    logic [29:0]   req_word;
    logic          push;
    logic          pop;
    logic [AW:0]   count_after;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc4;

    assign valid_IF  = (count != '0);
    assign pop       = valid_IF && IF_ID_write && !PCSrc;
    assign push      = (state == BUSY) && imem_ack && !PCSrc;
    assign next_pc   = fetch_pc + 32'd4;
    assign imem_req  = (state != IDLE);
    assign imem_addr = {req_word, 2'b00};

    always_comb begin
        count_after = count;
        if (push && !pop)      count_after = count + 1'b1;
        else if (pop && !push) count_after = count - 1'b1;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (PCSrc),
        .wr_instr   (imem_rdata),
        .wr_pc4     (imem_addr + 32'd4),
        .head_instr (head_instr),
        .head_pc4   (head_pc4),
        .count      (count)
    );

    assign instruction_IF = valid_IF ? head_instr : NOP_WORD;
    assign PC_sumado_IF   = valid_IF ? head_pc4   : 32'h0;

    // A request only starts with a free slot, so the pending word always fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_word <= RESET_PC[31:2];
        end else begin
            unique case (state)
                IDLE: begin
                    if (PCSrc) begin
                        fetch_pc <= PC_next_MEM;
                    end else if (count < DEPTH_C) begin
                        state    <= BUSY;
                        req_word <= fetch_pc[31:2];
                    end
                end
                BUSY: begin
                    if (PCSrc) begin
                        fetch_pc <= PC_next_MEM;
                        state    <= imem_ack ? IDLE : DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc <= next_pc;
                        if (count_after < DEPTH_C) req_word <= next_pc[31:2];
                        else                       state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (PCSrc)    fetch_pc <= PC_next_MEM;
                    if (imem_ack) state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Upstream neighbour of the IF/ID register: owns the fetch PC and issues requests to an instruction memory with variable latency using a req/ack handshake.
- Buffers returned words with their PC+4 in a small FIFO, and presents the head as instruction_IF / PC_sumado_IF.
- Honours decode-side stalls via IF_ID_write.
- Handles taken-branch redirects from MEM (PCSrc, PC_next_MEM), including discarding a response that is still in flight.

Parameters:
- DEPTH, 2: queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- NOP_WORD, 32'h0000_0000: instruction_IF value when the queue is empty.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_write  in  1  decode accepts the head entry this cycle (pop when valid_IF=1).
- PCSrc  in  1  taken-branch redirect.
- PC_next_MEM  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  response valid; may be the same cycle as req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instruction_IF  out  32  head instruction, or NOP_WORD when empty.
- PC_sumado_IF  out  32  head PC+4, or 0 when empty.
- valid_IF  out  1  queue not empty.
- count  out  $clog2(DEPTH)+1  occupancy, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, queue empty, count=0.
  - imem_req=0, imem_addr=RESET_PC.
  - valid_IF=0, instruction_IF=NOP_WORD, PC_sumado_IF=0, state=IDLE.
  - Reset mid-transaction abandons it; the memory side tolerates a dropped req.
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- IDLE -> BUSY: when count + pops_this_cycle... specifically, a request is issued when count < DEPTH (one slot is reserved) and PCSrc=0. It drives imem_req=1 and imem_addr=fetch_pc.
- Request handshake:
  - imem_req and imem_addr are held stable until the cycle imem_ack=1.
  - imem_req is never withdrawn before ack.
  - At most one request is outstanding.
- BUSY + ack, no redirect:
  - Push {imem_rdata, imem_addr+4}; fetch_pc += 4.
  - Next state is BUSY, back-to-back, if a slot remains after this cycle's push/pop; otherwise IDLE.
  - Throughput is 1 instr/cycle with zero-latency memory.
- Pop: when valid_IF && IF_ID_write, the head advances. Push and pop in the same cycle leave count unchanged.
- Invariant: count + (state!=IDLE) <= DEPTH. Overflow is impossible by construction; underflow is blocked by valid_IF gating.
- PCSrc=1 (highest priority, overrides push and pop):
  - Queue flushed, count=0 next cycle, fetch_pc=PC_next_MEM.
  - If BUSY without ack this cycle: go to DISCARD.
  - If ack this cycle, or IDLE: go to IDLE, then issue to PC_next_MEM the next cycle.
- DISCARD:
  - Hold the old req/addr until ack, then drop the data and go to IDLE.
  - A further PCSrc while in DISCARD only updates fetch_pc.
- Redirect latency: the first redirected word is visible on valid_IF at least 2 cycles after PCSrc, with zero-latency memory.
- Outputs are combinational from the queue head; no extra register stage.
- fetch_pc wraps modulo 2^32. Bits [1:0] are forced to 0 on imem_addr.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE, BUSY, DISCARD), entry struct {instr[31:0], pc4[31:0]}, NOP_WORD constant.
- Sub-module fetch_fifo: DEPTH-entry sync FIFO with async active-low reset; push/pop/flush inputs, head data, count output.
- The top contains the FSM, fetch_pc and handshake logic.

Test Plan:
- Reset, IF_ID_write=1, memory always acks same cycle with data=addr^32'hA5A5_0000 -> valid_IF rises; consecutive heads PC_sumado_IF=4,8,12; one instr per cycle.
- IF_ID_write=0 for 5 cycles -> count saturates at 2, imem_req=0 once full; release -> PC_sumado_IF continues 4,8,12 with no gap or duplicate.
- Memory ack after 3 cycles -> imem_req and imem_addr=0 held stable for 3 cycles; one push per ack; count never exceeds 2.
- PCSrc=1 with PC_next_MEM=32'h100 while request to 8 is outstanding (ack 2 cycles later) -> valid_IF=0 next cycle, addr 8 data dropped, next imem_addr=32'h100, head PC_sumado_IF=32'h104.
- PCSrc, push and pop in the same cycle -> count=0 next cycle; no stale entry appears.
- rst_n pulsed low mid-BUSY -> all outputs at reset values immediately (asynchronously); first request after release has imem_addr=RESET_PC.
